// File: rtl/fetch_controller_if.sv
// fetch_controller_if: instruction-memory, decode handshake and redirect
// signals of the fetch sequencer. The master side is the fetch controller.
interface fetch_controller_if #(
    parameter int DEPTH = 2
);
    // Instruction memory (combinational read)
    logic [63:0]              Inst_Address;
    logic [31:0]              Instruction;
    // Fetch control
    logic                     Fetch_En;
    // Decode handshake
    logic                     Out_Valid;
    logic                     Out_Ready;
    logic [31:0]              Out_Instruction;
    logic [63:0]              Out_PC;
    // Branch/jump redirect
    logic                     Redirect;
    logic [63:0]              Redirect_PC;
    // Status
    logic [$clog2(DEPTH):0]   Occupancy;
    logic                     Halted;
    logic                     Misalign;

    modport master (
        output Inst_Address,
        input  Instruction,
        input  Fetch_En,
        output Out_Valid,
        input  Out_Ready,
        output Out_Instruction,
        output Out_PC,
        input  Redirect,
        input  Redirect_PC,
        output Occupancy,
        output Halted,
        output Misalign
    );

    modport slave (
        input  Inst_Address,
        output Instruction,
        output Fetch_En,
        input  Out_Valid,
        output Out_Ready,
        input  Out_Instruction,
        input  Out_PC,
        output Redirect,
        output Redirect_PC,
        input  Occupancy,
        input  Halted,
        input  Misalign
    );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC, fetches one 32-bit word per enabled cycle
// into a DEPTH-entry prefetch queue and hands entries to decode over
// valid/ready. Redirects flush the queue and reload the PC.
// Optional feature macro FETCH_HALT_ON_BOUND_EN: when defined, an
// out-of-range PC halts fetch (Halted=1); otherwise the PC wraps to 0.
module fetch_controller #(
    parameter int          DEPTH     = 2,
    parameter int          MEM_BYTES = 160,
    parameter logic [63:0] RESET_PC  = 64'h0
) (
    input  logic               clk,
    input  logic               reset,
    fetch_controller_if.master bus
);
    localparam int          PTR_W   = $clog2(DEPTH);
    localparam int          CNT_W   = PTR_W + 1;
    localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - 4);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    fq_entry_t          q_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [63:0]        pc_q;
    logic               halted_q;
    logic               misalign_q;

    logic               pop, push;
    logic [63:0]        pc_cand, pc_next;
    logic               out_of_range;
    logic               halted_next;

    // Handshake decode and next-PC selection; redirect beats sequential fetch.
    always_comb begin
        pop          = (count != '0) && bus.Out_Ready;
        push         = bus.Fetch_En && !halted_q && !bus.Redirect &&
                       ((count < CNT_W'(DEPTH)) || pop);
        pc_cand      = pc_q;
        if (bus.Redirect)
            pc_cand = {bus.Redirect_PC[63:2], 2'b00};
        else if (push)
            pc_cand = pc_q + 64'd4;
        out_of_range = (pc_cand > LAST_PC);
`ifdef FETCH_HALT_ON_BOUND_EN
        // Out-of-range PC is kept so the stop point stays visible.
        pc_next      = pc_cand;
        halted_next  = out_of_range;
`else
        // Out-of-range PC wraps to the start of memory before it is fetched.
        pc_next      = out_of_range ? 64'h0 : pc_cand;
        halted_next  = 1'b0;
`endif
    end

    // PC, halt and sticky misalign state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_next;
            halted_q   <= halted_next;
            if (bus.Redirect && (bus.Redirect_PC[1:0] != 2'b00))
                misalign_q <= 1'b1;
        end
    end

    // Prefetch queue: circular buffer; a redirect discards all entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                q_mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.Redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_mem[wr_ptr] <= '{pc: pc_q, inst: bus.Instruction};
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // All outputs come straight from registers.
    assign bus.Inst_Address    = pc_q;
    assign bus.Out_Valid       = (count != '0);
    assign bus.Out_PC          = q_mem[rd_ptr].pc;
    assign bus.Out_Instruction = q_mem[rd_ptr].inst;
    assign bus.Occupancy       = count;
    assign bus.Halted          = halted_q;
    assign bus.Misalign        = misalign_q;
endmodule
